rob_marker_tracker: RTL and testbench
=====================================

Name: rob_marker_tracker

Overview:
- Sits between the core's ROB commit ports and the simulation sync/taint monitor.
- Scans every commit lane each cycle for phase-marker instructions (slti x0,x0,imm).
- Tracks the current test phase with a state machine and timestamps each marker.
- Serialises marker events through a multi-push/single-pop FIFO into a valid/ready stream for the monitor.

Parameters:
- NUM_LANES, 3: commit lanes scanned per cycle.
- FIFO_DEPTH, 8: event FIFO entries; power of two, at least NUM_LANES.
- CNT_W, 32: width of the cycle timestamp and phase-length counters.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- commit_valid  in  NUM_LANES  per-lane commit valid.
- commit_inst  in  NUM_LANES*32  per-lane committed instruction; lane i is bits [32i+31:32i].
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts the head.
- evt_code  out  4  marker code, imm[3:0].
- evt_lane  out  $clog2(NUM_LANES)  lane the marker committed on.
- evt_stamp  out  CNT_W  global cycle count at commit.
- cur_phase  out  3  current phase id; 7 means none.
- phase_cycles  out  CNT_W  cycles spent in the current phase, saturating.
- drop_count  out  16  dropped events, saturating.
- overflow  out  1  sticky; set on any drop.
- seq_err  out  1  sticky; set on any out-of-order marker.

Behaviour:
- Marker decode: inst[19:0]==20'h02013, inst[31:24]==0 and inst[23:20]<=4'hd. Codes 0xe and 0xf are not markers.
- code = inst[23:20]. Even code = start, odd code = end. phase = code>>1: 0 VCTM, 1 DELAY, 2 TEXE, 3 LEAK, 4 INIT, 5 BIM, 6 TRAIN.
- Reset values:
  - evt_valid=0, cur_phase=7, phase_cycles=0, drop_count=0, overflow=0, seq_err=0.
  - Global cycle counter=0; FIFO empty.
  - The evt_* payload is don't-care while evt_valid=0.
  - Reset mid-phase discards the state and all FIFO contents with no partial event.
- Global counter increments every cycle out of reset and wraps modulo 2^CNT_W.
- Each marker's evt_stamp is the counter value in its commit cycle. All lanes in one cycle share the same stamp.
- Event push:
  - Markers in a cycle are handled in ascending lane order.
  - Free slots are computed from the registered occupancy before this cycle's pop; a same-cycle pop does not free a slot for same-cycle pushes.
  - If k markers arrive with f free slots, the first min(k,f) are pushed.
  - The remaining k-f are dropped: drop_count += k-f (saturates at 16'hffff) and overflow is set.
  - A pushed entry is visible on evt_valid the next cycle (1-cycle latency).
- Pop: occurs when evt_valid && evt_ready. The head is stable while evt_valid=1 and evt_ready=0.
- Phase FSM, states IDLE and ACTIVE(p), stepped per marker in lane order within a cycle; drops do not affect it:
  - IDLE, start p -> ACTIVE(p), phase_cycles=0.
  - ACTIVE(p), end p -> IDLE.
  - IDLE, any end -> seq_err=1, stay IDLE.
  - ACTIVE(p), start q (including q==p) -> seq_err=1, ACTIVE(q), phase_cycles=0.
  - ACTIVE(p), end q with q!=p -> seq_err=1, IDLE.
- cur_phase and phase_cycles are registered and reflect the state after the last marker of the previous cycle.
- phase_cycles increments each cycle in ACTIVE, holds 0 in IDLE, and saturates at all-ones.
- Lanes with commit_valid=0 are ignored regardless of commit_inst.

Decomposition:
- Package rob_marker_pkg holds:
  - marker base constant 20'h02013 and the code constants 0x0..0xd;
  - phase enum (VCTM..TRAIN, NONE=7);
  - decode function returning {is_marker, is_start, phase};
  - the event struct {code, lane, stamp}.
- One sub-module, marker_evt_fifo: NUM_LANES-wide multi-push with a per-lane push mask, single pop, occupancy output.

Test Plan:
- Lane0 inst 32'h00002013 at cycle 10, evt_ready=1 -> event {code 0, lane 0, stamp 10} valid at cycle 11; cur_phase=0 from cycle 11.
- One cycle with lane0 32'h00c02013 and lane2 32'h00d02013 -> two events in order, codes 0xc then 0xd; cur_phase back to 7; seq_err=0.
- evt_ready=0 while 3 markers/cycle for 3 cycles, FIFO_DEPTH=8 -> 8 entries held, drop_count=1, overflow=1; the held head does not change.
- 32'h00302013 alone from IDLE -> event emitted, seq_err=1, cur_phase stays 7.
- 32'h00e02013 and 32'h00002093 (rd=1) committed -> no event, no state change.
- Enter TEXE (32'h00402013), hold 5 cycles, assert reset -> phase_cycles=0, cur_phase=7, evt_valid=0; a subsequent marker is stamped relative to the reset release.

Source files
------------

// File: rtl/rob_marker_pkg.sv
// Shared marker encoding, phase identifiers and event record for the ROB marker tracker.
// A marker is "slti x0,x0,imm" with imm[11:4]==0 and imm[3:0] as the code.
package rob_marker_pkg;

    localparam logic [19:0] MARKER_BASE = 20'h02013;

    localparam logic [3:0] CODE_VCTM_START  = 4'h0;
    localparam logic [3:0] CODE_VCTM_END    = 4'h1;
    localparam logic [3:0] CODE_DELAY_START = 4'h2;
    localparam logic [3:0] CODE_DELAY_END   = 4'h3;
    localparam logic [3:0] CODE_TEXE_START  = 4'h4;
    localparam logic [3:0] CODE_TEXE_END    = 4'h5;
    localparam logic [3:0] CODE_LEAK_START  = 4'h6;
    localparam logic [3:0] CODE_LEAK_END    = 4'h7;
    localparam logic [3:0] CODE_INIT_START  = 4'h8;
    localparam logic [3:0] CODE_INIT_END    = 4'h9;
    localparam logic [3:0] CODE_BIM_START   = 4'ha;
    localparam logic [3:0] CODE_BIM_END     = 4'hb;
    localparam logic [3:0] CODE_TRAIN_START = 4'hc;
    localparam logic [3:0] CODE_TRAIN_END   = 4'hd;

    // Event record widths: up to 16 lanes, stamps up to 32 bits.
    localparam int LANE_W  = 4;
    localparam int STAMP_W = 32;

    typedef enum logic [2:0] {
        PH_VCTM  = 3'd0,
        PH_DELAY = 3'd1,
        PH_TEXE  = 3'd2,
        PH_LEAK  = 3'd3,
        PH_INIT  = 3'd4,
        PH_BIM   = 3'd5,
        PH_TRAIN = 3'd6,
        PH_NONE  = 3'd7
    } phase_e;

    typedef struct packed {
        logic   is_marker;
        logic   is_start;
        phase_e phase;
    } marker_dec_t;

    typedef struct packed {
        logic [3:0]         code;
        logic [LANE_W-1:0]  lane;
        logic [STAMP_W-1:0] stamp;
    } marker_evt_t;

    function automatic marker_dec_t decode_marker(input logic [31:0] inst);
        marker_dec_t d;
        d.is_marker = (inst[19:0] == MARKER_BASE) && (inst[31:24] == 8'h00)
                      && (inst[23:20] <= CODE_TRAIN_END);
        d.is_start  = ~inst[20];
        d.phase     = phase_e'(inst[23:21]);
        return d;
    endfunction

endpackage

// File: rtl/rob_marker_tracker_fifo.sv
// Event FIFO: up to NUM_LANES pushes per cycle packed in lane order, one pop per cycle.
// The caller limits the push mask to the free slots; occupancy is the registered count.
module marker_evt_fifo
    import rob_marker_pkg::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int OCC_W     = PTR_W + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_LANES-1:0]         push_mask,
    input  marker_evt_t [NUM_LANES-1:0]  push_data,
    input  logic                         pop,
    output marker_evt_t                  head,
    output logic                         head_valid,
    output logic [OCC_W-1:0]             occupancy
);

    marker_evt_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic [PTR_W-1:0] slot [NUM_LANES];
    logic [OCC_W-1:0] push_cnt;
    logic             pop_fire;

    // Each pushing lane takes the next slot after the lower pushing lanes.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            slot[i] = wr_ptr_reg + push_cnt[PTR_W-1:0];
            if (push_mask[i]) push_cnt = push_cnt + OCC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push_mask[i]) mem[slot[i]] <= push_data[i];
        end
    end

    assign pop_fire = pop && (occ_reg != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + push_cnt[PTR_W-1:0];
            if (pop_fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            occ_reg    <= occ_reg + push_cnt - OCC_W'(pop_fire);
        end
    end

    assign head       = mem[rd_ptr_reg];
    assign head_valid = (occ_reg != '0);
    assign occupancy  = occ_reg;

endmodule

// File: rtl/rob_marker_tracker.sv
// Scans ROB commit lanes for phase markers, tracks the active test phase and
// streams timestamped marker events to the sync/taint monitor.
module rob_marker_tracker
    import rob_marker_pkg::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_LANES-1:0]         commit_valid,
    input  logic [NUM_LANES*32-1:0]      commit_inst,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [3:0]                   evt_code,
    output logic [$clog2(NUM_LANES)-1:0] evt_lane,
    output logic [CNT_W-1:0]             evt_stamp,
    output logic [2:0]                   cur_phase,
    output logic [CNT_W-1:0]             phase_cycles,
    output logic [15:0]                  drop_count,
    output logic                         overflow,
    output logic                         seq_err
);

    localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int LANE_OUT_W = $clog2(NUM_LANES);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    logic [CNT_W-1:0]            cycle_cnt_reg;
    state_e                      state_reg, state_next;
    phase_e                      phase_reg, phase_next;
    logic [CNT_W-1:0]            phase_cycles_reg, phase_cycles_next;
    logic [15:0]                 drop_count_reg, drop_count_next;
    logic [16:0]                 drop_sum;
    logic                        overflow_reg, overflow_next;
    logic                        seq_err_reg, seq_err_next;
    logic                        restart;
    logic [NUM_LANES-1:0]        lane_marker, push_mask;
    marker_dec_t [NUM_LANES-1:0] lane_dec;
    marker_evt_t [NUM_LANES-1:0] lane_evt;
    marker_evt_t                 head;
    logic [OCC_W-1:0]            occupancy, free_slots, mk_cnt, drop_n;
    logic                        unused_head;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lane_dec[gi]    = decode_marker(commit_inst[32*gi +: 32]);
        assign lane_marker[gi] = commit_valid[gi] & lane_dec[gi].is_marker;
        assign lane_evt[gi]    = '{code:  commit_inst[32*gi+20 +: 4],
                                   lane:  LANE_W'(gi),
                                   stamp: STAMP_W'(cycle_cnt_reg)};
    end

    // Markers are walked in lane order: the first free_slots are pushed and the
    // phase FSM is stepped once per marker, dropped ones included.
    always_comb begin
        free_slots   = OCC_W'(FIFO_DEPTH) - occupancy;
        mk_cnt       = '0;
        push_mask    = '0;
        state_next   = state_reg;
        phase_next   = phase_reg;
        seq_err_next = seq_err_reg;
        restart      = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_marker[i]) begin
                if (mk_cnt < free_slots) push_mask[i] = 1'b1;
                mk_cnt = mk_cnt + OCC_W'(1);
                if (lane_dec[i].is_start) begin
                    if (state_next == ST_ACTIVE) seq_err_next = 1'b1;
                    state_next = ST_ACTIVE;
                    phase_next = lane_dec[i].phase;
                    restart    = 1'b1;
                end else begin
                    if (state_next != ST_ACTIVE || phase_next != lane_dec[i].phase)
                        seq_err_next = 1'b1;
                    state_next = ST_IDLE;
                    phase_next = PH_NONE;
                end
            end
        end
        drop_n          = (mk_cnt > free_slots) ? (mk_cnt - free_slots) : '0;
        drop_sum        = {1'b0, drop_count_reg} + 17'(drop_n);
        drop_count_next = drop_sum[16] ? 16'hffff : drop_sum[15:0];
        overflow_next   = overflow_reg | (drop_n != '0);
        if (state_next == ST_IDLE || restart)
            phase_cycles_next = '0;
        else if (&phase_cycles_reg)
            phase_cycles_next = phase_cycles_reg;
        else
            phase_cycles_next = phase_cycles_reg + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt_reg    <= '0;
            state_reg        <= ST_IDLE;
            phase_reg        <= PH_NONE;
            phase_cycles_reg <= '0;
            drop_count_reg   <= '0;
            overflow_reg     <= 1'b0;
            seq_err_reg      <= 1'b0;
        end else begin
            cycle_cnt_reg    <= cycle_cnt_reg + CNT_W'(1);
            state_reg        <= state_next;
            phase_reg        <= phase_next;
            phase_cycles_reg <= phase_cycles_next;
            drop_count_reg   <= drop_count_next;
            overflow_reg     <= overflow_next;
            seq_err_reg      <= seq_err_next;
        end
    end

    marker_evt_fifo #(
        .NUM_LANES  (NUM_LANES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_mask  (push_mask),
        .push_data  (lane_evt),
        .pop        (evt_ready),
        .head       (head),
        .head_valid (evt_valid),
        .occupancy  (occupancy)
    );

    assign evt_code     = head.code;
    assign evt_lane     = LANE_OUT_W'(head.lane);
    assign evt_stamp    = CNT_W'(head.stamp);
    assign unused_head  = ^{head.lane, head.stamp};
    assign cur_phase    = phase_reg;
    assign phase_cycles = phase_cycles_reg;
    assign drop_count   = drop_count_reg;
    assign overflow     = overflow_reg;
    assign seq_err      = seq_err_reg;

endmodule

// File: tb/tb_rob_marker_tracker.sv
// Scoreboard bench for rob_marker_tracker: a reference model predicts events,
// phase state and drop counters; outputs are compared on every falling edge.
module tb_rob_marker_tracker;

    localparam int NL = 3;
    localparam int FD = 8;
    localparam int CW = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NL-1:0]   commit_valid = '0;
    logic [NL*32-1:0] commit_inst = '0;
    logic            evt_ready = 1'b0;
    logic            evt_valid;
    logic [3:0]      evt_code;
    logic [1:0]      evt_lane;
    logic [CW-1:0]   evt_stamp;
    logic [2:0]      cur_phase;
    logic [CW-1:0]   phase_cycles;
    logic [15:0]     drop_count;
    logic            overflow;
    logic            seq_err;

    always #5 clock = ~clock;

    rob_marker_tracker #(.NUM_LANES(NL), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_lane     (evt_lane),
        .evt_stamp    (evt_stamp),
        .cur_phase    (cur_phase),
        .phase_cycles (phase_cycles),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .seq_err      (seq_err)
    );

    typedef struct {
        logic [3:0]  code;
        int          lane;
        logic [31:0] stamp;
    } exp_evt_t;

    exp_evt_t    exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_cyc   = 0;
    int          m_phase = 7;
    logic [31:0] m_pcyc  = '0;
    int          m_drops = 0;
    bit          m_ovf   = 1'b0;
    bit          m_serr  = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic check_outputs();
        if (exp_q.size() > 0) begin
            check_val("evt_valid", 64'(evt_valid), 64'd1);
            check_val("evt_code",  64'(evt_code),  64'(exp_q[0].code));
            check_val("evt_lane",  64'(evt_lane),  64'(exp_q[0].lane));
            check_val("evt_stamp", 64'(evt_stamp), 64'(exp_q[0].stamp));
        end else begin
            check_val("evt_valid", 64'(evt_valid), 64'd0);
        end
        check_val("cur_phase",    64'(cur_phase),    64'(m_phase));
        check_val("phase_cycles", 64'(phase_cycles), 64'(m_pcyc));
        check_val("drop_count",   64'(drop_count),   64'(m_drops));
        check_val("overflow",     64'(overflow),     64'(m_ovf));
        check_val("seq_err",      64'(seq_err),      64'(m_serr));
    endtask

    function automatic bit tb_is_marker(input logic [31:0] inst);
        return (inst[19:0] == 20'h02013) && (inst[31:24] == 8'h00) && (inst[23:20] <= 4'hd);
    endfunction

    // Predict the effect of the coming rising edge on the model state.
    task automatic model_cycle(input logic [NL-1:0] v, input logic [NL*32-1:0] insts, input logic rdy);
        int          occ;
        int          pushed;
        bit          had_start;
        exp_evt_t    e;
        logic [31:0] inst;
        logic [3:0]  c;
        occ       = exp_q.size();
        pushed    = 0;
        had_start = 1'b0;
        if (occ > 0 && rdy) begin
            e = exp_q.pop_front();
            $display("[TB] pop  code=%0h lane=%0d stamp=%0d", e.code, e.lane, e.stamp);
        end
        for (int l = 0; l < NL; l++) begin
            inst = insts[32*l +: 32];
            if (v[l] && tb_is_marker(inst)) begin
                c = inst[23:20];
                if (pushed < FD - occ) begin
                    e.code  = c;
                    e.lane  = l;
                    e.stamp = 32'(m_cyc);
                    exp_q.push_back(e);
                    pushed++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
                if (c[0] == 1'b0) begin
                    if (m_phase != 7) m_serr = 1'b1;
                    m_phase   = int'(c >> 1);
                    had_start = 1'b1;
                end else begin
                    if (m_phase != int'(c >> 1)) m_serr = 1'b1;
                    m_phase = 7;
                end
            end
        end
        if (m_phase == 7 || had_start) m_pcyc = '0;
        else if (m_pcyc != 32'hffff_ffff) m_pcyc = m_pcyc + 32'd1;
        m_cyc++;
    endtask

    task automatic wait_check();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic drive(input logic [NL-1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] i2, input logic rdy);
        commit_valid = v;
        commit_inst  = {i2, i1, i0};
        evt_ready    = rdy;
        if (v != '0)
            $display("[TB] cycle %0d commit v=%b l0=%h l1=%h l2=%h ready=%b", m_cyc, v, i0, i1, i2, rdy);
        model_cycle(v, {i2, i1, i0}, rdy);
    endtask

    task automatic step(input logic [NL-1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] i2, input logic rdy);
        wait_check();
        drive(v, i0, i1, i2, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step('0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clock);
        reset        = 1'b0;
        commit_valid = '0;
        commit_inst  = '0;
        evt_ready    = 1'b0;
        exp_q.delete();
        m_phase = 7; m_pcyc = '0; m_drops = 0; m_ovf = 1'b0; m_serr = 1'b0; m_cyc = 0;
        #1;
        check_outputs();
        repeat (hold) @(negedge clock);
        check_outputs();
        reset = 1'b1;
        $display("[TB] reset released");
        model_cycle('0, '0, 1'b0);
    endtask

    function automatic logic [31:0] rand_inst();
        int         r;
        logic [3:0] c;
        r = $urandom_range(0, 9);
        c = 4'($urandom_range(0, 15));
        if (r < 7)       return {8'h00, c, 20'h02013};
        else if (r == 7) return {8'h01, c, 20'h02013};
        else             return 32'($urandom);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset(3);

        // First marker: VCTM start on lane 0 at cycle 10.
        while (m_cyc < 10) step('0, 32'h0, 32'h0, 32'h0, 1'b1);
        step(3'b001, 32'h00002013, 32'h0, 32'h0, 1'b1);
        wait_check();
        check_val("tp1_stamp", 64'(evt_stamp), 64'd10);
        check_val("tp1_phase", 64'(cur_phase), 64'd0);
        drive('0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Close VCTM, then TRAIN start+end in one cycle on lanes 0 and 2.
        step(3'b001, 32'h00102013, 32'h0, 32'h0, 1'b1);
        step(3'b101, 32'h00c02013, 32'h0, 32'h00d02013, 1'b1);
        idle(1, 1'b1);
        wait_check();
        check_val("tp2_code_b", 64'(evt_code), 64'hd);
        check_val("tp2_lane_b", 64'(evt_lane), 64'd2);
        check_val("tp2_phase",  64'(cur_phase), 64'd7);
        check_val("tp2_seqerr", 64'(seq_err), 64'd0);
        drive('0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Non-markers and an invalid lane carrying a marker.
        step(3'b011, 32'h00e02013, 32'h00002093, 32'h0, 1'b1);
        step(3'b010, 32'h00402013, 32'h0, 32'h0, 1'b1);
        wait_check();
        check_val("tp5_valid", 64'(evt_valid), 64'd0);
        check_val("tp5_phase", 64'(cur_phase), 64'd7);
        drive('0, 32'h0, 32'h0, 32'h0, 1'b1);

        // End marker from IDLE.
        step(3'b001, 32'h00302013, 32'h0, 32'h0, 1'b1);
        wait_check();
        check_val("tp4_code",   64'(evt_code),  64'h3);
        check_val("tp4_seqerr", 64'(seq_err),   64'd1);
        check_val("tp4_phase",  64'(cur_phase), 64'd7);
        drive('0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Back-pressure: 9 markers into 8 slots.
        repeat (3) step(3'b111, 32'h00802013, 32'h00902013, 32'h00a02013, 1'b0);
        idle(3, 1'b0);
        wait_check();
        check_val("tp3_drops", 64'(drop_count), 64'd1);
        check_val("tp3_ovf",   64'(overflow),   64'd1);
        check_val("tp3_head",  64'(evt_code),   64'h8);
        drive('0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle(10, 1'b1);

        // TEXE held with pending events, then reset.
        step(3'b011, 32'h00402013, 32'h00602013, 32'h0, 1'b0);
        idle(5, 1'b0);
        wait_check();
        check_val("tp6_cycles", 64'(phase_cycles), 64'd5);
        drive('0, 32'h0, 32'h0, 32'h0, 1'b0);
        apply_reset(2);
        idle(3, 1'b1);
        step(3'b010, 32'h0, 32'h00a02013, 32'h0, 1'b1);
        wait_check();
        check_val("tp6_stamp", 64'(evt_stamp), 64'd4);
        check_val("tp6_lane",  64'(evt_lane),  64'd1);
        drive('0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Random traffic with random back-pressure, then drain.
        repeat (80) step(NL'($urandom), rand_inst(), rand_inst(), rand_inst(),
                         ($urandom_range(0, 3) != 0));
        idle(12, 1'b1);
        wait_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
